// File: rtl/taxi_fare_pkg.sv
// Shared definitions for the taxi fare meter.
// Contents: trip state encoding and packed-BCD helper constants/functions.
package taxi_fare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  localparam int unsigned MAX_DIGITS = 16;

  // All-9s pattern; slice the low 4*N bits for an N-digit saturation value.
  localparam logic [4*MAX_DIGITS-1:0] BCD_NINES = {MAX_DIGITS{4'h9}};

  // Elaboration-time conversion of an integer to packed BCD.
  function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int unsigned v);
    logic [4*MAX_DIGITS-1:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/taxi_fare_meter_bcd_add_sat.sv
// N-digit packed-BCD adder (ripple per digit).
// Ports: i_a, i_b  - BCD operands (4*N bits)
//        o_sum     - BCD sum, low 4*N bits
//        o_cout    - carry out of the top digit (caller saturates on it)
module bcd_add_sat #(
  parameter int unsigned N = 4
) (
  input  logic [4*N-1:0] i_a,
  input  logic [4*N-1:0] i_b,
  output logic [4*N-1:0] o_sum,
  output logic           o_cout
);

  always_comb begin : add_digits
    logic       c;
    logic [4:0] s;
    c     = 1'b0;
    s     = '0;
    o_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s = {1'b0, i_a[4*i +: 4]} + {1'b0, i_b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      o_sum[4*i +: 4] = s[3:0];
    end
    o_cout = c;
  end

endmodule

// File: rtl/taxi_fare_meter.sv
// Taxi fare meter: packed-BCD fare and distance accumulator with base distance,
// per-trip day/night rate latch, waiting-time charging and saturation flags.
// Ports: clk, rst (sync, active-high); trip_start/trip_end/trip_clear pulses;
//        wait_en level; night_sel (sampled at trip start); ten_meter_pulse
//        (async, rising edge = 10 m); s_fare, dist_rate_day/night,
//        wait_fare_per_unit BCD inputs; fare_bcd, dist_bcd, state,
//        fare_full, dist_full registered outputs.
module taxi_fare_meter
  import taxi_fare_pkg::*;
#(
  parameter int unsigned FARE_DIGITS = 4,
  parameter int unsigned DIST_DIGITS = 4,
  parameter int unsigned MIN_COUNT   = 10,
  parameter int unsigned WAIT_COUNT  = 5,
  parameter int unsigned BASE_DIST   = 300
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trip_start,
  input  logic                     trip_end,
  input  logic                     trip_clear,
  input  logic                     wait_en,
  input  logic                     night_sel,
  input  logic                     ten_meter_pulse,
  input  logic [4*FARE_DIGITS-1:0] s_fare,
  input  logic [4*FARE_DIGITS-1:0] dist_rate_day,
  input  logic [4*FARE_DIGITS-1:0] dist_rate_night,
  input  logic [4*FARE_DIGITS-1:0] wait_fare_per_unit,
  output logic [4*FARE_DIGITS-1:0] fare_bcd,
  output logic [4*DIST_DIGITS-1:0] dist_bcd,
  output logic [1:0]               state,
  output logic                     fare_full,
  output logic                     dist_full
);

  localparam int unsigned FW = 4 * FARE_DIGITS;
  localparam int unsigned DW = 4 * DIST_DIGITS;
  localparam int unsigned PW = (MIN_COUNT  > 1) ? $clog2(MIN_COUNT)  : 1;
  localparam int unsigned MW = (WAIT_COUNT > 1) ? $clog2(WAIT_COUNT) : 1;

  localparam logic [FW-1:0] FARE_NINES = BCD_NINES[FW-1:0];
  localparam logic [DW-1:0] DIST_NINES = BCD_NINES[DW-1:0];
  localparam logic [4*MAX_DIGITS-1:0] BASE_BCD_FULL = int_to_bcd(BASE_DIST);
  // Packed BCD orders the same as its decimal value, so a plain compare works.
  localparam logic [DW-1:0] BASE_BCD  = BASE_BCD_FULL[DW-1:0];
  localparam logic [PW-1:0] PRE_LAST  = PW'(MIN_COUNT - 1);
  localparam logic [MW-1:0] MIN_LAST  = MW'(WAIT_COUNT - 1);

  state_t        r_state;
  logic [FW-1:0] r_fare;
  logic [DW-1:0] r_dist;
  logic [FW-1:0] r_rate;
  logic          r_fare_full;
  logic          r_dist_full;
  logic [PW-1:0] r_pre;
  logic [MW-1:0] r_min;
  logic          r_p_s1, r_p_s2, r_p_d;

  logic          w_edge;
  logic [FW-1:0] w_fare_addend;
  logic [FW-1:0] w_fare_sum;
  logic          w_fare_cout;
  logic [DW-1:0] w_dist_one;
  logic [DW-1:0] w_dist_sum;
  logic          w_dist_cout;

  assign w_edge        = r_p_s2 & ~r_p_d;
  assign w_fare_addend = (r_state == ST_WAIT) ? wait_fare_per_unit : r_rate;
  assign w_dist_one    = DW'(1);

  // One fare adder shared by distance and waiting charges (mutually exclusive states).
  bcd_add_sat #(.N(FARE_DIGITS)) u_fare_add (
    .i_a    (r_fare),
    .i_b    (w_fare_addend),
    .o_sum  (w_fare_sum),
    .o_cout (w_fare_cout)
  );

  bcd_add_sat #(.N(DIST_DIGITS)) u_dist_add (
    .i_a    (r_dist),
    .i_b    (w_dist_one),
    .o_sum  (w_dist_sum),
    .o_cout (w_dist_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fare      <= '0;
      r_dist      <= '0;
      r_rate      <= '0;
      r_fare_full <= 1'b0;
      r_dist_full <= 1'b0;
      r_pre       <= '0;
      r_min       <= '0;
      r_p_s1      <= 1'b0;
      r_p_s2      <= 1'b0;
      r_p_d       <= 1'b0;
    end else begin
      r_p_s1 <= ten_meter_pulse;
      r_p_s2 <= r_p_s1;
      r_p_d  <= r_p_s2;
      // Wait counters only survive while counting in WAIT; every other path clears them.
      r_pre  <= '0;
      r_min  <= '0;

      if (trip_clear) begin
        r_state     <= ST_IDLE;
        r_fare      <= '0;
        r_dist      <= '0;
        r_fare_full <= 1'b0;
        r_dist_full <= 1'b0;
      end else if (trip_end && (r_state == ST_RUN || r_state == ST_WAIT)) begin
        r_state <= ST_HOLD;
      end else if (trip_start && (r_state == ST_IDLE || r_state == ST_HOLD)) begin
        r_state     <= ST_RUN;
        r_fare      <= s_fare;
        r_dist      <= '0;
        r_fare_full <= 1'b0;
        r_dist_full <= 1'b0;
        r_rate      <= night_sel ? dist_rate_night : dist_rate_day;
      end else if (r_state == ST_RUN) begin
        if (wait_en) begin
          r_state <= ST_WAIT;
        end else if (w_edge) begin
          if (w_dist_cout) begin
            r_dist      <= DIST_NINES;
            r_dist_full <= 1'b1;
          end else begin
            r_dist <= w_dist_sum;
          end
          if (!r_dist_full && !r_fare_full && (r_dist >= BASE_BCD)) begin
            if (w_fare_cout) begin
              r_fare      <= FARE_NINES;
              r_fare_full <= 1'b1;
            end else begin
              r_fare <= w_fare_sum;
            end
          end
        end
      end else if (r_state == ST_WAIT) begin
        if (!wait_en) begin
          r_state <= ST_RUN;
        end else if (r_pre == PRE_LAST) begin
          if (r_min == MIN_LAST) begin
            if (!r_fare_full) begin
              if (w_fare_cout) begin
                r_fare      <= FARE_NINES;
                r_fare_full <= 1'b1;
              end else begin
                r_fare <= w_fare_sum;
              end
            end
          end else begin
            r_min <= r_min + MW'(1);
          end
        end else begin
          r_pre <= r_pre + PW'(1);
          r_min <= r_min;
        end
      end
    end
  end

  assign fare_bcd  = r_fare;
  assign dist_bcd  = r_dist;
  assign state     = r_state;
  assign fare_full = r_fare_full;
  assign dist_full = r_dist_full;

endmodule
